// File: rtl/xil_bram_rd_prefetch_pkg.sv
// Shared definitions for the block RAM read prefetcher: pointer/counter width
// helpers, the default skid depth and the skid FIFO operation encoding.
package xil_bram_rd_prefetch_pkg;

  localparam int DEF_ADR = 10;
  localparam int DEF_DAT = 18;
  localparam int DEF_DEL = 1;

  // {push, pop} as seen by the skid FIFO in one cycle
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_width(input int adr);
    return adr + 1;
  endfunction

  // DEL+2 words of skid storage sustains one word per clock.
  function automatic int default_skd(input int del);
    return del + 2;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/xil_reg_fifo.sv
// Small register FIFO used as the read-latency skid buffer; head entry always
// sits in mem[0] so dout needs no read mux.
module xil_reg_fifo
  import xil_bram_rd_prefetch_pkg::*;
#(
  parameter int DAT = 18,
  parameter int SKD = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DAT-1:0]              din,
  output logic [DAT-1:0]              dout,
  output logic [cnt_width(SKD)-1:0]   occ
);

  localparam int CW = cnt_width(SKD);

  logic [DAT-1:0] mem     [SKD];
  logic [DAT-1:0] shifted [SKD];
  logic           pop_ok;
  fifo_op_e       op;

  assign pop_ok = pop && (occ != '0);
  assign op     = fifo_op_e'({push, pop_ok});
  assign dout   = (occ != '0) ? mem[0] : '0;

  always_comb begin
    for (int k = 0; k < SKD - 1; k++) shifted[k] = mem[k+1];
    shifted[SKD-1] = '0;
  end

  // Pop shifts everything toward the head; a simultaneous push lands in the
  // slot that the last live entry vacates, so order is preserved.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      occ <= '0;
      for (int k = 0; k < SKD; k++) mem[k] <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          for (int k = 0; k < SKD; k++)
            if (CW'(k) == occ) mem[k] <= din;
          occ <= occ + CW'(1);
        end
        OP_POP: begin
          for (int k = 0; k < SKD; k++) mem[k] <= shifted[k];
          occ <= occ - CW'(1);
        end
        OP_BOTH: begin
          for (int k = 0; k < SKD; k++)
            mem[k] <= (CW'(k) == occ - CW'(1)) ? din : shifted[k];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/xil_bram_rd_prefetch.sv
// Read-side controller for a DEL-latency simple dual-port block RAM: issues
// reads up to the writer's commit pointer and presents a valid/ready stream.
module xil_bram_rd_prefetch
  import xil_bram_rd_prefetch_pkg::*;
#(
  parameter int ADR = DEF_ADR,
  parameter int DAT = DEF_DAT,
  parameter int DEL = DEF_DEL,
  parameter int SKD = default_skd(DEL)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic [ADR:0]   wptr,
  output logic [ADR:0]   rptr,
  output logic           ren,
  output logic [ADR-1:0] rad,
  input  logic [DAT-1:0] rda,
  output logic [DAT-1:0] dout,
  output logic           dvld,
  input  logic           drdy,
  output logic           empty
);

  localparam int PW = ptr_width(ADR);
  localparam int CW = cnt_width(SKD);
  localparam logic [CW:0] SKD_CNT = (CW+1)'(SKD);

  logic [PW-1:0]  iptr;
  logic [CW-1:0]  infl;
  logic [CW-1:0]  occ;
  logic [DEL-1:0] pipe;
  logic [CW:0]    used;
  logic           tail;
  logic           pop;

  // Credit counts only registered state, so drdy never reaches ren or rad.
  assign used  = {1'b0, infl} + {1'b0, occ};
  assign ren   = (iptr != wptr) && (used < SKD_CNT) && !flush && !rst;
  assign rad   = iptr[ADR-1:0];
  assign tail  = pipe[DEL-1];
  assign dvld  = (occ != '0);
  assign pop   = dvld && drdy;
  assign empty = (iptr == wptr) && (infl == '0) && (occ == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      iptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      iptr <= wptr;
      rptr <= wptr;
    end else begin
      if (ren) iptr <= iptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  // Clearing the pipe on flush is what discards returns of earlier reads.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pipe <= '0;
      infl <= '0;
    end else begin
      pipe[0] <= ren;
      for (int k = 1; k < DEL; k++) pipe[k] <= pipe[k-1];
      infl <= infl + CW'(ren) - CW'(tail);
    end
  end

  xil_reg_fifo #(
    .DAT (DAT),
    .SKD (SKD)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (tail),
    .pop   (pop),
    .din   (rda),
    .dout  (dout),
    .occ   (occ)
  );

endmodule

// File: tb/tb_xil_bram_rd_prefetch.sv
// Bench for xil_bram_rd_prefetch: one DEL=1 and one DEL=3 instance share the
// writer, checked each cycle against a committed-word stream model.
module tb_xil_bram_rd_prefetch;

  localparam int ADR   = 4;
  localparam int DAT   = 18;
  localparam int DEPTH = 16;
  localparam int NI    = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           drdy = 1'b0;
  logic           clr_stats = 1'b0;
  logic [ADR:0]   wptr = '0;
  logic [DAT-1:0] ram [DEPTH];

  logic [NI-1:0]  ren, dvld, empty;
  logic [ADR:0]   rptr [NI];
  logic [ADR-1:0] rad  [NI];
  logic [DAT-1:0] rda  [NI];
  logic [DAT-1:0] dout [NI];

  int cyc = 0;
  int cmp_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Each instance: its own RAM read pipe, the DUT, and a stream model where
  // the word at the consumed pointer is always the next one that must appear.
  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int D = (g == 0) ? 1 : 3;
    localparam int S = D + 2;

    logic [DAT-1:0] rpipe [D];
    logic [ADR:0]   m_rptr = '0;
    logic [ADR:0]   m_iptr = '0;
    logic [ADR:0]   diff;
    int ren_cnt = 0, pop_cnt = 0, dv_cnt = 0, first_dv = -1, last_dv = -1;

    xil_bram_rd_prefetch #(
      .ADR (ADR),
      .DAT (DAT),
      .DEL (D)
    ) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .wptr  (wptr),
      .rptr  (rptr[g]),
      .ren   (ren[g]),
      .rad   (rad[g]),
      .rda   (rda[g]),
      .dout  (dout[g]),
      .dvld  (dvld[g]),
      .drdy  (drdy),
      .empty (empty[g])
    );

    always @(posedge clk) begin
      rpipe[0] <= ram[rad[g]];
      for (int k = 1; k < D; k++) rpipe[k] <= rpipe[k-1];
    end
    assign rda[g] = rpipe[D-1];

    always @(negedge clk) begin
      if (rst) begin
        checkOutput("ren_in_rst", g, ren[g], 0);
        m_rptr = '0;
        m_iptr = '0;
      end else begin
        checkOutput("rptr", g, rptr[g], m_rptr);
        checkOutput("empty", g, empty[g], m_rptr == wptr);
        diff = wptr - rptr[g];
        checkOutput("rptr_le_wptr", g, diff <= 16, 1);
        if (dvld[g]) begin
          checkOutput("data_avail", g, m_rptr != wptr, 1);
          checkOutput("dout", g, dout[g], ram[m_rptr[ADR-1:0]]);
        end else begin
          checkOutput("dout_idle", g, dout[g], 0);
        end
        if (flush) checkOutput("ren_in_flush", g, ren[g], 0);
        if (ren[g]) begin
          checkOutput("rad", g, rad[g], m_iptr[ADR-1:0]);
          checkOutput("issue_le_wptr", g, m_iptr != wptr, 1);
          diff = m_iptr - m_rptr;
          checkOutput("credit", g, diff < S, 1);
        end
        if (flush) begin
          m_rptr = wptr;
          m_iptr = wptr;
        end else begin
          if (ren[g]) m_iptr = m_iptr + 1'b1;
          if (dvld[g] && drdy) m_rptr = m_rptr + 1'b1;
        end
      end
      if (clr_stats) begin
        ren_cnt = 0; pop_cnt = 0; dv_cnt = 0; first_dv = -1; last_dv = -1;
      end else begin
        if (ren[g]) ren_cnt++;
        if (dvld[g] && drdy && !rst && !flush) pop_cnt++;
        if (dvld[g] && !rst) begin
          dv_cnt++;
          if (first_dv < 0) first_dv = cyc;
          last_dv = cyc;
        end
      end
    end
  end

  function automatic int del_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int stat_ren(input int i);
    return (i == 0) ? g_inst[0].ren_cnt : g_inst[1].ren_cnt;
  endfunction
  function automatic int stat_pop(input int i);
    return (i == 0) ? g_inst[0].pop_cnt : g_inst[1].pop_cnt;
  endfunction
  function automatic int stat_dv(input int i);
    return (i == 0) ? g_inst[0].dv_cnt : g_inst[1].dv_cnt;
  endfunction
  function automatic int stat_span(input int i);
    return (i == 0) ? (g_inst[0].last_dv - g_inst[0].first_dv + 1)
                    : (g_inst[1].last_dv - g_inst[1].first_dv + 1);
  endfunction

  // The writer may commit only while neither reader is a full RAM behind.
  function automatic bit has_space();
    logic [ADR:0] d0, d1;
    d0 = wptr - g_inst[0].m_rptr;
    d1 = wptr - g_inst[1].m_rptr;
    return (d0 < DEPTH) && (d1 < DEPTH);
  endfunction

  task automatic applyStimulus(input bit do_commit, input bit rdy, input bit fl,
                               input logic [DAT-1:0] val, output bit done);
    @(posedge clk);
    #1;
    drdy  = rdy;
    flush = fl;
    done  = 1'b0;
    if (do_commit && has_space()) begin
      ram[wptr[ADR-1:0]] = val;
      wptr = wptr + 1'b1;
      done = 1'b1;
    end
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    rst = 1'b1; flush = 1'b0; drdy = 1'b0; wptr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic sampleCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic clearStats();
    clr_stats = 1'b1;
    sampleCycle();
    clr_stats = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit d;
    for (int c = 0; c < budget; c++) begin
      applyStimulus(0, 1, 0, '0, d);
      sampleCycle();
      if (&empty) break;
    end
    for (int i = 0; i < NI; i++) checkOutput("drain_empty", i, empty[i], 1);
  endtask

  initial begin
    bit d;
    int n;
    for (int a = 0; a < DEPTH; a++) ram[a] = '0;

    // Reset state, then idle with nothing committed
    applyReset();
    sampleCycle();
    for (int i = 0; i < NI; i++) begin
      checkOutput("rst_ren", i, ren[i], 0);
      checkOutput("rst_dvld", i, dvld[i], 0);
      checkOutput("rst_dout", i, dout[i], 0);
      checkOutput("rst_rptr", i, rptr[i], 0);
      checkOutput("rst_empty", i, empty[i], 1);
    end
    for (int c = 0; c < 20; c++) begin
      applyStimulus(0, 1, 0, '0, d);
      sampleCycle();
      for (int i = 0; i < NI; i++) checkOutput("idle_ren", i, ren[i], 0);
    end

    // Single word: issue in the commit cycle, valid DEL+1 cycles later
    applyStimulus(1, 1, 0, 18'h2A5, d);
    for (int k = 0; k < 6; k++) begin
      sampleCycle();
      for (int i = 0; i < NI; i++) begin
        if (k == 0) begin
          checkOutput("single_ren", i, ren[i], 1);
          checkOutput("single_rad", i, rad[i], 0);
        end
        checkOutput("single_dvld", i, dvld[i], k == del_of(i) + 1);
        if (k == del_of(i) + 1) checkOutput("single_dout", i, dout[i], 18'h2A5);
      end
      if (k < 5) applyStimulus(0, 1, 0, '0, d);
    end
    for (int i = 0; i < NI; i++) begin
      checkOutput("single_rptr", i, rptr[i], 1);
      checkOutput("single_empty", i, empty[i], 1);
    end

    // Stream of 40 words through an address wrap, one per clock
    applyReset();
    clearStats();
    n = 0;
    for (int c = 0; c < 200 && n < 40; c++) begin
      applyStimulus(1, 1, 0, DAT'($urandom), d);
      if (d) n++;
    end
    drain(100);
    for (int i = 0; i < NI; i++) begin
      checkOutput("stream_rptr", i, rptr[i], 8);
      checkOutput("stream_pops", i, stat_pop(i), 40);
      checkOutput("stream_dv_cycles", i, stat_dv(i), 40);
      checkOutput("stream_no_bubble", i, stat_span(i), 40);
    end

    // Backpressure: issue stops at the skid depth, head holds, then drains
    clearStats();
    for (int k = 0; k < 10; k++) applyStimulus(1, 0, 0, DAT'(18'h100 + k), d);
    repeat (15) applyStimulus(0, 0, 0, '0, d);
    sampleCycle();
    for (int i = 0; i < NI; i++) begin
      checkOutput("bp_issued", i, stat_ren(i), del_of(i) + 2);
      checkOutput("bp_dvld", i, dvld[i], 1);
      checkOutput("bp_dout_hold", i, dout[i], 18'h100);
      checkOutput("bp_no_pop", i, stat_pop(i), 0);
    end
    drain(100);
    for (int i = 0; i < NI; i++) begin
      checkOutput("bp_pops", i, stat_pop(i), 10);
      checkOutput("bp_rptr", i, rptr[i], 18);
    end

    // Flush with two reads in flight in the DEL=3 instance
    applyStimulus(1, 1, 0, 18'h3A1, d);
    applyStimulus(1, 1, 0, 18'h3A2, d);
    applyStimulus(0, 1, 1, '0, d);
    sampleCycle();
    checkOutput("pre_flush_dvld", 1, dvld[1], 0);
    checkOutput("pre_flush_dout", 0, dout[0], 18'h3A1);
    applyStimulus(0, 1, 0, '0, d);
    sampleCycle();
    for (int i = 0; i < NI; i++) begin
      checkOutput("flush_dvld", i, dvld[i], 0);
      checkOutput("flush_rptr", i, rptr[i], 20);
      checkOutput("flush_empty", i, empty[i], 1);
    end
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, 1, 0, '0, d);
      sampleCycle();
      for (int i = 0; i < NI; i++) checkOutput("flush_late_dvld", i, dvld[i], 0);
    end
    applyStimulus(1, 1, 0, 18'h0BEE, d);
    drain(20);
    for (int i = 0; i < NI; i++) checkOutput("resume_rptr", i, rptr[i], 21);

    // Random drdy, commit and rare flush traffic
    for (int c = 0; c < 10000; c++) begin
      bit fl;
      fl = ($urandom_range(0, 199) == 0);
      applyStimulus(!fl && ($urandom_range(0, 2) != 0), 1'($urandom), fl, DAT'($urandom), d);
    end
    drain(200);
    for (int i = 0; i < NI; i++) checkOutput("final_rptr", i, rptr[i], wptr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
